// File: rtl/aes_pkg.sv
// Shared widths, FSM state type and mode encodings for the AES input sequencer.
package aes_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_WORD_W      = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    HOLD
  } state_t;

endpackage

// File: rtl/aes_word_assembler.sv
// Word-indexed 4x32 register presented as one 128-bit block.
// Index 0 lands in the most significant word.
module aes_word_assembler
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [WORD_IDX_W-1:0]  index,
  input  logic [AES_WORD_W-1:0]  word,
  output logic [AES_BLOCK_W-1:0] block
);

  logic [AES_WORD_W-1:0] words [WORDS_PER_BLOCK];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) words[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) words[i] <= '0;
    end else if (load) begin
      words[index] <= word;
    end
  end

  assign block = {words[0], words[1], words[2], words[3]};

endmodule

// File: rtl/aes_input_sequencer.sv
// Collects key/data words into 128-bit blocks, then runs the AES core through
// clear, enable-until-done and a short hold before flagging the result.
module aes_input_sequencer
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int HOLD_CYCLES    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [AES_WORD_W-1:0]  s_data,
  input  logic                   s_is_key,
  input  logic                   s_mode,
  output logic                   core_reset,
  output logic                   core_enable,
  output logic                   core_mode,
  output logic [AES_BLOCK_W-1:0] core_key,
  output logic [AES_BLOCK_W-1:0] core_data,
  input  logic                   core_done,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int RUN_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

  state_t                state, state_next;
  logic [WORD_IDX_W-1:0] key_cnt, data_cnt;
  logic                  key_valid;
  logic [RUN_W-1:0]      run_cnt;
  logic [HOLD_W-1:0]     hold_cnt;

  logic accept, key_load, data_load, launch;
  logic done_seen, run_last, hold_last;

  assign accept    = s_valid && s_ready;
  assign key_load  = accept && s_is_key;
  assign data_load = accept && !s_is_key;
  assign launch    = data_load && (data_cnt == LAST_IDX);

  // The core was just cleared, so a done seen in the first RUN cycle is stale.
  assign done_seen = core_done && (run_cnt != '0);
  assign run_last  = (run_cnt == RUN_W'(TIMEOUT_CYCLES - 1));
  assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  aes_word_assembler u_key_asm (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .load    (key_load),
    .index   (key_cnt),
    .word    (s_data),
    .block   (core_key)
  );

  aes_word_assembler u_data_asm (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .load    (data_load),
    .index   (data_cnt),
    .word    (s_data),
    .block   (core_data)
  );

  always_comb begin
    state_next   = state;
    core_reset   = 1'b0;
    core_enable  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    s_ready      = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        s_ready = reset_n && (s_is_key || key_valid);
        if (launch) state_next = CLR;
      end
      CLR: begin
        core_reset = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        core_enable = 1'b1;
        if (done_seen)     state_next = HOLD;
        else if (run_last) state_next = IDLE;
      end
      HOLD: begin
        if (hold_last) begin
          result_valid = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      key_cnt     <= '0;
      data_cnt    <= '0;
      key_valid   <= 1'b0;
      run_cnt     <= '0;
      hold_cnt    <= '0;
      core_mode   <= MODE_ENC;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      run_cnt  <= (state == RUN)  ? run_cnt + 1'b1  : '0;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      if (key_load) begin
        key_cnt <= key_cnt + 1'b1;
        if (key_cnt == LAST_IDX) key_valid <= 1'b1;
      end
      if (data_load) data_cnt <= data_cnt + 1'b1;
      if (launch) begin
        core_mode   <= s_mode;
        timeout_err <= 1'b0;
      end else if (state == RUN && !done_seen && run_last) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_input_sequencer.sv
// Randomized self-checking bench for aes_input_sequencer with a stand-in core
// whose done timing is chosen per block.
module tb_aes_input_sequencer;

  localparam int TIMEOUT = 32;
  localparam int HOLD    = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_is_key = 1'b0;
  logic         s_mode = 1'b0;
  logic         core_reset, core_enable, core_mode;
  logic [127:0] core_key, core_data;
  logic         core_done = 1'b0;
  logic         result_valid, busy, timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: assembled blocks, word counts and flags.
  logic [127:0] key_m, data_m;
  int           kc, dc;
  bit           kv_m, mode_m, terr_m;

  aes_input_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_is_key     (s_is_key),
    .s_mode       (s_mode),
    .core_reset   (core_reset),
    .core_enable  (core_enable),
    .core_mode    (core_mode),
    .core_key     (core_key),
    .core_data    (core_data),
    .core_done    (core_done),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    key_m = '0; data_m = '0; kc = 0; dc = 0;
    kv_m = 0; mode_m = 0; terr_m = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_s_ready"}, s_ready, 0);
    check_output({tag, "_key"}, core_key, '0);
    check_output({tag, "_data"}, core_data, '0);
    check_output({tag, "_mode"}, core_mode, 0);
    check_output({tag, "_core_reset"}, core_reset, 0);
    check_output({tag, "_enable"}, core_enable, 0);
    check_output({tag, "_result"}, result_valid, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_timeout"}, timeout_err, 0);
  endtask

  // Called at a negedge; leaves the bench at a later negedge with reset released.
  task automatic do_reset();
    reset_n  = 1'b0;
    s_valid  = 1'b1;
    s_is_key = 1'b1;
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    s_valid = 1'b0;
  endtask

  // Presents one word for one cycle in IDLE and updates the model if it is taken.
  task automatic offer(input bit is_key, input logic [31:0] w, input bit mode, output bit launched);
    bit exp_ready;
    launched = 0;
    s_valid  = 1'b1;
    s_is_key = is_key;
    s_data   = w;
    s_mode   = mode;
    #1;
    check_output("idle_busy", busy, 0);
    check_output("idle_timeout", timeout_err, terr_m);
    check_output("idle_key", core_key, key_m);
    check_output("idle_data", core_data, data_m);
    exp_ready = is_key || kv_m;
    check_output("s_ready", s_ready, exp_ready);
    if (exp_ready) begin
      if (is_key) begin
        key_m[(3 - kc) * 32 +: 32] = w;
        if (kc == 3) kv_m = 1;
        kc = (kc + 1) % 4;
      end else begin
        data_m[(3 - dc) * 32 +: 32] = w;
        if (dc == 3) begin
          launched = 1;
          mode_m   = mode;
          terr_m   = 0;
        end
        dc = (dc + 1) % 4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Runs one block after launch. done_at: first RUN cycle (1-based) the core
  // raises done, 0 = never. reset_at: RUN cycle to assert reset, 0 = none.
  task automatic run_block(input int done_at, input int reset_at);
    bit finished = 0;
    s_valid  = 1'b1;
    s_is_key = 1'($urandom_range(0, 1));
    s_data   = $urandom;
    #1;
    check_output("clr_core_reset", core_reset, 1);
    check_output("clr_enable", core_enable, 0);
    check_output("clr_busy", busy, 1);
    check_output("clr_result", result_valid, 0);
    check_output("clr_s_ready", s_ready, 0);
    check_output("clr_timeout", timeout_err, 0);
    check_output("clr_key", core_key, key_m);
    check_output("clr_data", core_data, data_m);
    check_output("clr_mode", core_mode, mode_m);
    @(posedge clk);
    @(negedge clk);
    for (int r = 1; r <= TIMEOUT; r++) begin
      core_done = (done_at != 0) && (r >= done_at);
      s_is_key  = 1'($urandom_range(0, 1));
      if (r == reset_at) begin
        reset_n  = 1'b0;
        s_is_key = 1'b1;
        #1;
        check_all_zero("midrun");
        model_reset();
        @(negedge clk);
        reset_n   = 1'b1;
        s_valid   = 1'b0;
        core_done = 1'b0;
        return;
      end
      #1;
      check_output("run_enable", core_enable, 1);
      check_output("run_core_reset", core_reset, 0);
      check_output("run_result", result_valid, 0);
      check_output("run_s_ready", s_ready, 0);
      check_output("run_key", core_key, key_m);
      @(posedge clk);
      @(negedge clk);
      if (r >= 2 && core_done) begin
        finished = 1;
        break;
      end
      if (r == TIMEOUT) terr_m = 1;
    end
    if (finished) begin
      for (int h = 1; h <= HOLD; h++) begin
        #1;
        check_output("hold_enable", core_enable, 0);
        check_output("hold_busy", busy, 1);
        check_output("hold_result", result_valid, h == HOLD);
        check_output("hold_data", core_data, data_m);
        @(posedge clk);
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    #1;
    check_output("end_busy", busy, 0);
    check_output("end_result", result_valid, 0);
    check_output("end_enable", core_enable, 0);
    check_output("end_timeout", timeout_err, terr_m);
    @(negedge clk);
  endtask

  task automatic send_group(input bit is_key, input logic [127:0] blk, input bit mode, output bit launched);
    bit l;
    launched = 0;
    for (int i = 0; i < 4; i++) begin
      offer(is_key, blk[(3 - i) * 32 +: 32], mode, l);
      if (l) launched = 1;
    end
  endtask

  task automatic random_done(output int d);
    d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 36));
  endtask

  initial begin
    bit           l;
    int           d;
    logic [127:0] kb, db;
    model_reset();
    @(negedge clk);
    do_reset();

    // Known-answer block, encrypt.
    send_group(1, 128'h2b7e151628aed2a6abf7158809cf4f3c, aes_pkg::MODE_ENC, l);
    send_group(0, 128'h3243f6a8885a308d313198a2e0370734, aes_pkg::MODE_ENC, l);
    check_output("kat_launch", l, 1);
    check_output("kat_key", core_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    if (l) run_block(10, 0);
    core_done = 1'b0;

    // Data before any key is refused; after the key it is taken at once.
    do_reset();
    offer(0, 32'hdeadbeef, 0, l);
    offer(0, 32'hdeadbeef, 0, l);
    send_group(1, 128'h000102030405060708090a0b0c0d0e0f, 0, l);
    send_group(0, 128'h00112233445566778899aabbccddeeff, 0, l);
    if (l) run_block(5, 0);

    // Core never completes: timeout after TIMEOUT RUN cycles.
    core_done = 1'b0;
    send_group(0, {$urandom, $urandom, $urandom, $urandom}, 0, l);
    if (l) run_block(0, 0);
    check_output("timeout_flag", timeout_err, 1);

    // Next block clears the flag; done left high afterwards.
    send_group(0, {$urandom, $urandom, $urandom, $urandom}, 1, l);
    if (l) run_block(3, 0);

    // Stale done high through CLR; completion on RUN cycle 2.
    check_output("stale_done_driven", core_done, 1);
    send_group(0, {$urandom, $urandom, $urandom, $urandom}, 0, l);
    if (l) run_block(1, 0);

    // Interleaved key and data words, last data word in decrypt mode.
    kb = {$urandom, $urandom, $urandom, $urandom};
    db = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      offer(1, kb[(3 - i) * 32 +: 32], 0, l);
      offer(0, db[(3 - i) * 32 +: 32], (i == 3), l);
    end
    check_output("ilv_launch", l, 1);
    check_output("ilv_key", core_key, kb);
    check_output("ilv_data", core_data, db);
    if (l) run_block(4, 0);
    check_output("ilv_mode", core_mode, 1);

    // Random traffic with random completion times.
    repeat (20) begin
      l = 0;
      for (int n = 0; n < 40 && !l; n++)
        offer(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), l);
      for (int n = 0; n < 4 && !l; n++)
        offer(0, $urandom, 1'($urandom_range(0, 1)), l);
      check_output("rand_launch", l, 1);
      random_done(d);
      if (l) run_block(d, 0);
    end

    // Reset in the middle of RUN; key_valid must be gone afterwards.
    send_group(0, {$urandom, $urandom, $urandom, $urandom}, 1, l);
    if (l) run_block(20, 6);
    #1;
    check_output("post_reset_key", core_key, '0);
    offer(0, 32'h12345678, 0, l);
    offer(1, 32'hcafef00d, 0, l);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aes_input_sequencer.md
Name: aes_input_sequencer

Overview:
Upstream stage of the AES-128 core. It accepts key and plaintext/ciphertext as 32-bit words over a valid/ready stream and assembles 128-bit key and data blocks. It then sequences the core: a one-cycle clear pulse, enable held until the core's sticky done, and a hold window so the core's registered data_out settles. It reports result_valid to the downstream consumer and flags a timeout if the core never completes.

Parameters:
TIMEOUT_CYCLES, 32, max RUN cycles waiting for core_done before abort (must be >= 12)
HOLD_CYCLES, 2, cycles after core_done before result_valid (covers core's extra data_out register stage)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid && s_ready
s_data  in  32  input word
s_is_key  in  1  1 = key word, 0 = data word
s_mode  in  1  0 = encrypt, 1 = decrypt; sampled with 4th data word
core_reset  out  1  active-high clear to core (one-cycle pulse)
core_enable  out  1  core enable
core_mode  out  1  registered mode to core
core_key  out  128  assembled key
core_data  out  128  assembled data block
core_done  in  1  core done (sticky until core_reset)
result_valid  out  1  one-cycle pulse: core data_out valid this cycle
busy  out  1  high in CLR/RUN/HOLD
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; key_cnt=data_cnt=0; key_valid=0; core_key=core_data=0; core_mode=0; core_reset=0; core_enable=0; result_valid=0; timeout_err=0; s_ready=0 while in reset.
- Word order: first accepted word of a group -> bits [127:96], 4th -> [31:0]. Separate 2-bit counters for key and data words; each wraps 3->0 on group completion.
- Key path: key word accepted in IDLE only. 4th key word sets key_valid=1. A new key group overwrites words in place; key_valid stays 1, and the new key takes effect at the next CLR.
- Data path: data word accepted in IDLE only if key_valid=1; else s_ready=0 for data words. Key and data groups may interleave word by word.
- s_ready = (state==IDLE) && (s_is_key || key_valid).
- FSM:
  - IDLE: on acceptance of 4th data word, latch core_mode<=s_mode and clear timeout_err, then go to CLR next cycle.
  - CLR (1 cycle): core_reset=1, core_enable=0, then go to RUN.
  - RUN: core_enable=1 and a cycle counter runs from 0. If core_done=1, go to HOLD with core_enable=0 from the next cycle. Otherwise, if the counter reaches TIMEOUT_CYCLES-1, set timeout_err=1 and go to IDLE without result_valid.
  - HOLD: count HOLD_CYCLES cycles; on the last one result_valid=1 for exactly one cycle, then go to IDLE.
- Latency: from 4th data word accept to result_valid = 1 (CLR) + RUN cycles until core_done + HOLD_CYCLES.
- core_done high during CLR is ignored (stale sticky done from the prior block). RUN never samples done in its first cycle because the core was cleared.
- core_key/core_data are stable from CLR through HOLD; no input is accepted while busy.
- Reset mid-operation: immediate return to reset values. Partial word groups and key_valid are lost.
- s_valid with s_ready=0: no state change; the word must be held by the source.

Decomposition:
- Package aes_pkg: AES_BLOCK_W=128, AES_WORD_W=32, WORDS_PER_BLOCK=4, state enum {IDLE, CLR, RUN, HOLD}, MODE_ENC=0/MODE_DEC=1 constants.
- Sub-module aes_word_assembler: 4x32 -> 128 word-indexed register with load strobe, index input and clear. Instantiated twice, once for key and once for data.

Test Plan:
- Load key 2b7e1516_28aed2a6_abf71588_09cf4f3c, then data 3243f6a8_885a308d_313198a2_e0370734 with mode=0 -> core_key/core_data match bit-for-bit; one core_reset pulse; core_enable high until core_done; result_valid exactly HOLD_CYCLES cycles after done.
- Data words before any key -> s_ready=0 for data words; key words accepted. After the 4th key word, the pending data word is accepted the next cycle.
- core_done tied low -> timeout_err=1 after exactly 32 RUN cycles, no result_valid, FSM back in IDLE; next block clears timeout_err on its 4th data word.
- core_done held high from the previous block -> CLR pulse issued and done ignored during CLR; completion follows the RUN-cycle rule.
- Interleave key word, data word, key word… with the last data word carrying mode=1 -> both groups assemble correctly and core_mode=1.
- reset_n asserted mid-RUN -> all outputs return to reset values in the same cycle; key_valid=0; s_ready=0 until reset release.
